// File: rtl/rr_logging_packer_pkg.sv
// -----------------------------------------------------------------------------
// cl_fpgarr_defs
//   Definitions shared by the record-path packer and the trace storage backend.
//   The width and length helpers live here so that both sides compute a unit's
//   length from its bitmap in the same way.
// -----------------------------------------------------------------------------
package cl_fpgarr_defs;

    localparam int RR_CHANNEL_WIDTH_BITS = 8;
    // Upper bound on logb channels that the helper functions can describe.
    localparam int RR_MAX_CHANNELS       = 16;

    typedef bit [RR_MAX_CHANNELS-1:0][RR_CHANNEL_WIDTH_BITS-1:0] rr_width_tbl_t;
    typedef bit [RR_MAX_CHANNELS-1:0]                            rr_bitmap_t;

    // Sum of the widths of channels [0, idx).
    function automatic int rr_prefix_width(input rr_width_tbl_t widths, input int idx);
        int sum;
        sum = 0;
        for (int j = 0; j < RR_MAX_CHANNELS; j++) begin
            if (j < idx) sum += int'(widths[j]);
        end
        return sum;
    endfunction

    // Length of a unit with every channel valid.
    function automatic int rr_full_width(input int logb_cnt, input int loge_cnt,
                                         input rr_width_tbl_t widths);
        return rr_prefix_width(widths, logb_cnt) + logb_cnt + loge_cnt;
    endfunction

    // Length of a unit as decoded from its logb bitmap.
    function automatic int rr_unit_len(input int logb_cnt, input int loge_cnt,
                                       input rr_width_tbl_t widths, input rr_bitmap_t bitmap);
        int sum;
        sum = logb_cnt + loge_cnt;
        for (int j = 0; j < RR_MAX_CHANNELS; j++) begin
            if (j < logb_cnt && bitmap[j]) sum += int'(widths[j]);
        end
        return sum;
    endfunction

endpackage

// File: rtl/rr_stream_bus_t.sv
// -----------------------------------------------------------------------------
// rr_stream_bus_t
//   Record stream toward the storage backend: one variable-length unit per
//   valid&ready beat.
//   valid/ready : handshake
//   data        : unit bits, LSB first, zero at and above len
//   len         : number of meaningful bits in data
// -----------------------------------------------------------------------------
interface rr_stream_bus_t #(
    parameter int FULL_WIDTH   = 61,
    parameter int OFFSET_WIDTH = $clog2(FULL_WIDTH + 1)
);
    logic                    valid;
    logic                    ready;
    logic [FULL_WIDTH-1:0]   data;
    logic [OFFSET_WIDTH-1:0] len;

    modport P (output valid, data, len, input ready);
    modport C (input valid, data, len, output ready);
endinterface

// File: rtl/rr_packer_compact.sv
// -----------------------------------------------------------------------------
// rr_packer_compact
//   Combinational compaction: header (bitmap, loge) at the LSBs, then every
//   valid logb payload shifted to header + its prefix offset, ORed together.
//   bitmap  : logb valid bits
//   loge    : loge valid bits
//   payload : raw channel payloads at their fixed offsets
//   prefix  : per-channel sum of valid widths below that channel
//   data    : packed unit, zero above its length
// -----------------------------------------------------------------------------
module rr_packer_compact
    import cl_fpgarr_defs::*;
#(
    parameter int LOGB_CHANNEL_CNT = 3,
    parameter bit [LOGB_CHANNEL_CNT-1:0][RR_CHANNEL_WIDTH_BITS-1:0] CHANNEL_WIDTHS = {8'd32, 8'd16, 8'd8},
    parameter int LOGE_CHANNEL_CNT = 2,
    parameter int PAYLOAD_WIDTH    = 56,
    parameter int FULL_WIDTH       = 61,
    parameter int OFFSET_WIDTH     = 6
)(
    input  logic [LOGB_CHANNEL_CNT-1:0]                   bitmap,
    input  logic [LOGE_CHANNEL_CNT-1:0]                   loge,
    input  logic [PAYLOAD_WIDTH-1:0]                      payload,
    input  logic [LOGB_CHANNEL_CNT-1:0][OFFSET_WIDTH-1:0] prefix,
    output logic [FULL_WIDTH-1:0]                         data
);

    localparam int HDR_WIDTH = LOGB_CHANNEL_CNT + LOGE_CHANNEL_CNT;

    logic [LOGB_CHANNEL_CNT-1:0][FULL_WIDTH-1:0] placed;

    for (genvar g = 0; g < LOGB_CHANNEL_CNT; g++) begin : g_chan
        localparam int W    = int'(CHANNEL_WIDTHS[g]);
        localparam int BASE = rr_prefix_width(rr_width_tbl_t'(CHANNEL_WIDTHS), g);
        logic [OFFSET_WIDTH-1:0] dst;
        // dst + W never exceeds FULL_WIDTH, so no payload bit is shifted out.
        assign dst       = OFFSET_WIDTH'(HDR_WIDTH) + prefix[g];
        assign placed[g] = bitmap[g] ? (FULL_WIDTH'(payload[BASE +: W]) << dst) : '0;
    end

    always_comb begin
        // NOTE: data gets a complete value before the loop; every path assigns it, so no latch.
        data = FULL_WIDTH'({loge, bitmap});
        for (int i = 0; i < LOGB_CHANNEL_CNT; i++) begin
            data = data | placed[i];
        end
    end

endmodule

// File: rtl/rr_logging_packer.sv
// -----------------------------------------------------------------------------
// rr_logging_packer
//   Packs the per-cycle logb/loge events into one variable-length logging unit
//   and streams it to the trace storage backend. Two pipeline stages, one unit
//   per cycle, valid/ready backpressure.
//   clk, rstn  : clock, asynchronous active-low reset
//   logb_valid : per-channel logb events
//   logb_data  : logb payloads, channel 0 at the LSB
//   loge_valid : per-channel loge events
//   in_ready   : the current event inputs are consumed this cycle
//   record_bus : unit stream (valid/ready/data/len)
//   unit_cnt   : units handed to the backend
//   stall_cnt  : cycles with a unit waiting on ready
// -----------------------------------------------------------------------------
module rr_logging_packer
    import cl_fpgarr_defs::*;
#(
    parameter int LOGB_CHANNEL_CNT = 3,
    parameter bit [LOGB_CHANNEL_CNT-1:0][RR_CHANNEL_WIDTH_BITS-1:0] CHANNEL_WIDTHS = {8'd32, 8'd16, 8'd8},
    parameter int LOGE_CHANNEL_CNT = 2,
    localparam int PAYLOAD_WIDTH = rr_prefix_width(rr_width_tbl_t'(CHANNEL_WIDTHS), LOGB_CHANNEL_CNT),
    localparam int FULL_WIDTH    = rr_full_width(LOGB_CHANNEL_CNT, LOGE_CHANNEL_CNT,
                                                 rr_width_tbl_t'(CHANNEL_WIDTHS)),
    localparam int OFFSET_WIDTH  = $clog2(FULL_WIDTH + 1)
)(
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [LOGB_CHANNEL_CNT-1:0] logb_valid,
    input  logic [PAYLOAD_WIDTH-1:0]    logb_data,
    input  logic [LOGE_CHANNEL_CNT-1:0] loge_valid,
    output logic                        in_ready,
    rr_stream_bus_t.P                   record_bus,
    output logic [63:0]                 unit_cnt,
    output logic [63:0]                 stall_cnt
);

    localparam rr_width_tbl_t WIDTH_TBL = rr_width_tbl_t'(CHANNEL_WIDTHS);

    if (record_bus.FULL_WIDTH != FULL_WIDTH) begin : g_bad_bus
        $error("rr_logging_packer: record_bus.FULL_WIDTH differs from the packer FULL_WIDTH");
    end
    for (genvar g = 0; g < LOGB_CHANNEL_CNT; g++) begin : g_width_chk
        if (CHANNEL_WIDTHS[g] == 0) begin : g_zero
            $error("rr_logging_packer: CHANNEL_WIDTHS entry is zero");
        end
    end

    logic in_valid;
    logic s1_en;
    logic s2_en;

    logic                                         s1_valid;
    logic [LOGB_CHANNEL_CNT-1:0]                  s1_bitmap;
    logic [LOGE_CHANNEL_CNT-1:0]                  s1_loge;
    logic [PAYLOAD_WIDTH-1:0]                     s1_payload;
    logic [LOGB_CHANNEL_CNT-1:0][OFFSET_WIDTH-1:0] s1_prefix;

    logic                    s2_valid;
    logic [FULL_WIDTH-1:0]   s2_data;
    logic [OFFSET_WIDTH-1:0] s2_len;

    logic [LOGB_CHANNEL_CNT-1:0][OFFSET_WIDTH-1:0] prefix_next;
    logic [FULL_WIDTH-1:0]                         compact_data;

    assign in_valid = (|logb_valid) | (|loge_valid);
    assign s2_en    = !s2_valid || record_bus.ready;
    assign s1_en    = !s1_valid || s2_en;
    assign in_ready = s1_en;

    // Running sum of the valid widths below each channel.
    always_comb begin
        logic [OFFSET_WIDTH-1:0] acc;
        prefix_next = '0;
        acc         = '0;
        for (int i = 0; i < LOGB_CHANNEL_CNT; i++) begin
            prefix_next[i] = acc;
            if (logb_valid[i]) acc = acc + OFFSET_WIDTH'(WIDTH_TBL[i]);
        end
    end

    rr_packer_compact #(
        .LOGB_CHANNEL_CNT(LOGB_CHANNEL_CNT),
        .CHANNEL_WIDTHS  (CHANNEL_WIDTHS),
        .LOGE_CHANNEL_CNT(LOGE_CHANNEL_CNT),
        .PAYLOAD_WIDTH   (PAYLOAD_WIDTH),
        .FULL_WIDTH      (FULL_WIDTH),
        .OFFSET_WIDTH    (OFFSET_WIDTH)
    ) u_compact (
        .bitmap (s1_bitmap),
        .loge   (s1_loge),
        .payload(s1_payload),
        .prefix (s1_prefix),
        .data   (compact_data)
    );

    // NOTE: datapath registers are reset too, so data/len read 0 after reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid   <= 1'b0;
            s1_bitmap  <= '0;
            s1_loge    <= '0;
            s1_payload <= '0;
            s1_prefix  <= '0;
            s2_valid   <= 1'b0;
            s2_data    <= '0;
            s2_len     <= '0;
        end else begin
            // NOTE: non-blocking so S2 samples the S1 contents from before this edge.
            if (s1_en) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_bitmap  <= logb_valid;
                    s1_loge    <= loge_valid;
                    s1_payload <= logb_data;
                    s1_prefix  <= prefix_next;
                end
            end
            if (s2_en) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data <= compact_data;
                    s2_len  <= OFFSET_WIDTH'(rr_unit_len(LOGB_CHANNEL_CNT, LOGE_CHANNEL_CNT,
                                                         WIDTH_TBL, rr_bitmap_t'(s1_bitmap)));
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            unit_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (s2_valid && record_bus.ready)  unit_cnt  <= unit_cnt + 64'd1;
            if (s2_valid && !record_bus.ready) stall_cnt <= stall_cnt + 64'd1;
        end
    end

    assign record_bus.valid = s2_valid;
    assign record_bus.data  = s2_data;
    assign record_bus.len   = s2_len;

endmodule

// File: tb/tb_rr_logging_packer.sv
// -----------------------------------------------------------------------------
// tb_rr_logging_packer
//   Directed vectors, backpressure and mid-stream reset sequences, and a
//   randomized stream checked against a bit-level packing model.
// -----------------------------------------------------------------------------
module tb_rr_logging_packer;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [2:0]  logb_valid = '0;
    logic [55:0] logb_data = '0;
    logic [1:0]  loge_valid = '0;
    logic        in_ready;
    logic [63:0] unit_cnt;
    logic [63:0] stall_cnt;

    rr_stream_bus_t #(.FULL_WIDTH(61)) bus();

    rr_logging_packer dut (
        .clk       (clk),
        .rstn      (rstn),
        .logb_valid(logb_valid),
        .logb_data (logb_data),
        .loge_valid(loge_valid),
        .in_ready  (in_ready),
        .record_bus(bus),
        .unit_cnt  (unit_cnt),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  b;
        logic [55:0] d;
        logic [1:0]  e;
        logic [60:0] xd;
        logic [5:0]  xl;
    } vec_t;

    typedef struct {
        logic [60:0] d;
        logic [5:0]  l;
    } exp_t;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] b, input logic [55:0] d, input logic [1:0] e);
        logb_valid = b;
        logb_data  = d;
        loge_valid = e;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        drive(3'b000, 56'h0, 2'b00);
        bus.ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) rstn = 1'b1;
        step();
    endtask

    // Bit-level packing model: header, then valid payloads back to back.
    function automatic exp_t model(input logic [2:0] b, input logic [55:0] d, input logic [1:0] e);
        exp_t r;
        int   pos;
        int   src [3];
        int   w   [3];
        src = '{0, 8, 24};
        w   = '{8, 16, 32};
        r.d = '0;
        r.d[2:0] = b;
        r.d[4:3] = e;
        pos = 5;
        for (int c = 0; c < 3; c++) begin
            if (b[c]) begin
                for (int k = 0; k < w[c]; k++) r.d[pos + k] = d[src[c] + k];
                pos += w[c];
            end
        end
        r.l = 6'(pos);
        return r;
    endfunction

    // Streams n units; ready is high with probability rdy_pct percent.
    task automatic stream(input int n, input int rdy_pct, input bit rand_bits, output int ready_low);
        exp_t        q[$];
        exp_t        x;
        int          sent, got, cycles;
        bit          have, prev_stall;
        logic [60:0] prev_d;
        logic [5:0]  prev_l;
        sent = 0; got = 0; cycles = 0; have = 0; prev_stall = 0; ready_low = 0;
        prev_d = '0; prev_l = '0;
        while (got < n && cycles < 4 * n + 50) begin
            bus.ready = ($urandom_range(99) < rdy_pct);
            if (!have && sent < n) begin
                if (rand_bits) begin
                    do begin
                        logb_valid = 3'($urandom_range(7));
                        loge_valid = 2'($urandom_range(3));
                    end while (logb_valid == 3'b000 && loge_valid == 2'b00);
                end else begin
                    logb_valid = 3'b111;
                    loge_valid = 2'b11;
                end
                logb_data = 56'({$urandom(), $urandom()});
                have = 1;
            end else if (!have) begin
                drive(3'b000, 56'h0, 2'b00);
            end
            #1;
            if (prev_stall) begin
                check("stall data hold", 64'(bus.data), 64'(prev_d));
                check("stall len hold", 64'(bus.len), 64'(prev_l));
            end
            prev_stall = bus.valid && !bus.ready;
            prev_d = bus.data;
            prev_l = bus.len;
            if (bus.valid && bus.ready) begin
                if (q.size() == 0) begin
                    check("unexpected unit", 64'(bus.valid), 64'd0);
                end else begin
                    x = q.pop_front();
                    check($sformatf("stream unit%0d data", got), 64'(bus.data), 64'(x.d));
                    check($sformatf("stream unit%0d len", got), 64'(bus.len), 64'(x.l));
                end
                got++;
            end
            if (have && in_ready) begin
                q.push_back(model(logb_valid, logb_data, loge_valid));
                sent++;
                have = 0;
            end else if (have) begin
                ready_low++;
            end
            step();
            cycles++;
        end
        if (got < n) check("stream cycle budget", 64'(got), 64'(n));
        drive(3'b000, 56'h0, 2'b00);
        bus.ready = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [8];
        int   seen;
        int   rl;

        vecs[0] = '{3'b101, {32'hDEADBEEF, 16'h0000, 8'hAB}, 2'b01,
                    {16'h0, 32'hDEADBEEF, 8'hAB, 2'b01, 3'b101}, 6'd45};
        vecs[1] = '{3'b000, {32'h12345678, 16'h9ABC, 8'hDE}, 2'b10,
                    61'b10000, 6'd5};
        vecs[2] = '{3'b111, {32'h44556677, 16'h2233, 8'h11}, 2'b11,
                    {32'h44556677, 16'h2233, 8'h11, 2'b11, 3'b111}, 6'd61};
        vecs[3] = '{3'b010, {32'hFFFFFFFF, 16'hBEEF, 8'h77}, 2'b00,
                    {40'h0, 16'hBEEF, 2'b00, 3'b010}, 6'd21};
        vecs[4] = '{3'b100, {32'hCAFEF00D, 16'h5555, 8'h66}, 2'b00,
                    {24'h0, 32'hCAFEF00D, 2'b00, 3'b100}, 6'd37};
        vecs[5] = '{3'b011, {32'h87654321, 16'hA5C3, 8'h5A}, 2'b10,
                    {32'h0, 16'hA5C3, 8'h5A, 2'b10, 3'b011}, 6'd29};
        vecs[6] = '{3'b001, {32'h11111111, 16'h2222, 8'hFF}, 2'b01,
                    {48'h0, 8'hFF, 2'b01, 3'b001}, 6'd13};
        vecs[7] = '{3'b110, {32'h89ABCDEF, 16'h1234, 8'h99}, 2'b00,
                    {8'h0, 32'h89ABCDEF, 16'h1234, 2'b00, 3'b110}, 6'd53};

        // Reset state.
        do_reset();
        check("reset valid", 64'(bus.valid), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset unit_cnt", unit_cnt, 64'd0);
        check("reset stall_cnt", stall_cnt, 64'd0);
        check("reset data", 64'(bus.data), 64'd0);
        check("reset len", 64'(bus.len), 64'd0);

        // Directed vectors, one at a time, ready held high.
        foreach (vecs[i]) begin
            drive(vecs[i].b, vecs[i].d, vecs[i].e);
            step();
            drive(3'b000, 56'h0, 2'b00);
            check($sformatf("vec%0d early valid", i), 64'(bus.valid), 64'd0);
            step();
            check($sformatf("vec%0d valid", i), 64'(bus.valid), 64'd1);
            check($sformatf("vec%0d data", i), 64'(bus.data), 64'(vecs[i].xd));
            check($sformatf("vec%0d len", i), 64'(bus.len), 64'(vecs[i].xl));
            step();
        end
        check("vectors unit_cnt", unit_cnt, 64'd8);
        check("vectors stall_cnt", stall_cnt, 64'd0);

        // All-zero inputs never form a unit.
        seen = 0;
        repeat (10) begin
            step();
            if (bus.valid) seen++;
        end
        check("idle units seen", 64'(seen), 64'd0);
        check("idle unit_cnt", unit_cnt, 64'd8);

        // 100 full-width units back to back.
        do_reset();
        stream(100, 100, 1'b0, rl);
        check("b2b in_ready low cycles", 64'(rl), 64'd0);
        check("b2b unit_cnt", unit_cnt, 64'd100);
        check("b2b stall_cnt", stall_cnt, 64'd0);

        // Backpressure: ready low for 5 valid cycles.
        do_reset();
        bus.ready = 1'b0;
        drive(vecs[0].b, vecs[0].d, vecs[0].e);
        step();
        check("bp in_ready after 1 accept", 64'(in_ready), 64'd1);
        drive(vecs[2].b, vecs[2].d, vecs[2].e);
        step();
        drive(3'b000, 56'h0, 2'b00);
        check("bp in_ready after 2 accepts", 64'(in_ready), 64'd0);
        check("bp valid", 64'(bus.valid), 64'd1);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp hold%0d data", k), 64'(bus.data), 64'(vecs[0].xd));
            check($sformatf("bp hold%0d in_ready", k), 64'(in_ready), 64'd0);
            step();
        end
        check("bp stall_cnt", stall_cnt, 64'd5);
        bus.ready = 1'b1;
        step();
        check("bp second unit data", 64'(bus.data), 64'(vecs[2].xd));
        check("bp second unit len", 64'(bus.len), 64'(vecs[2].xl));
        check("bp unit_cnt 1", unit_cnt, 64'd1);
        step();
        check("bp drained valid", 64'(bus.valid), 64'd0);
        check("bp unit_cnt 2", unit_cnt, 64'd2);
        check("bp stall_cnt final", stall_cnt, 64'd5);

        // Asynchronous reset with both stages full.
        do_reset();
        bus.ready = 1'b0;
        drive(vecs[0].b, vecs[0].d, vecs[0].e);
        step();
        drive(vecs[1].b, vecs[1].d, vecs[1].e);
        step();
        drive(3'b000, 56'h0, 2'b00);
        step();
        check("pre-reset stall_cnt", stall_cnt, 64'd1);
        #2 rstn = 1'b0;
        #1;
        check("async reset valid", 64'(bus.valid), 64'd0);
        check("async reset stall_cnt", stall_cnt, 64'd0);
        check("async reset unit_cnt", unit_cnt, 64'd0);
        check("async reset data", 64'(bus.data), 64'd0);
        check("async reset len", 64'(bus.len), 64'd0);
        @(negedge clk) rstn = 1'b1;
        step();
        check("post-reset in_ready", 64'(in_ready), 64'd1);
        check("post-reset valid", 64'(bus.valid), 64'd0);
        bus.ready = 1'b1;
        drive(vecs[3].b, vecs[3].d, vecs[3].e);
        step();
        drive(3'b000, 56'h0, 2'b00);
        check("post-reset early valid", 64'(bus.valid), 64'd0);
        step();
        check("post-reset unit valid", 64'(bus.valid), 64'd1);
        check("post-reset unit data", 64'(bus.data), 64'(vecs[3].xd));
        check("post-reset unit len", 64'(bus.len), 64'(vecs[3].xl));
        step();

        // Random bitmaps and random ready.
        do_reset();
        stream(10000, 70, 1'b1, rl);
        check("random unit_cnt", unit_cnt, 64'd10000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/rr_logging_packer.md
Name: rr_logging_packer

Overview:
- Record-path stage directly upstream of the AXI trace storage backend.
- Each cycle it samples the per-channel log-begin (logb) and log-end (loge) events and compacts them into one variable-length logging unit.
- It drives the unit, with its exact bit length, onto the record rr_stream_bus_t that the storage backend consumes.
- Two-stage pipeline, full throughput, standard valid/ready backpressure.

Parameters:
- LOGB_CHANNEL_CNT, 3: number of logb channels.
- CHANNEL_WIDTHS, {32,16,8}: bit [LOGB_CHANNEL_CNT-1:0][RR_CHANNEL_WIDTH_BITS-1:0]. Entry [i] is the payload width of logb channel i (default [0]=8, [1]=16, [2]=32). Already in shuffled order.
- LOGE_CHANNEL_CNT, 2: number of loge channels.
- Derived FULL_WIDTH = sum(CHANNEL_WIDTHS) + LOGB_CHANNEL_CNT + LOGE_CHANNEL_CNT (default 61).
- Derived OFFSET_WIDTH = $clog2(FULL_WIDTH+1).

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- logb_valid  in  LOGB_CHANNEL_CNT  per-channel logb event this cycle.
- logb_data  in  sum(CHANNEL_WIDTHS)  channel payloads concatenated; channel 0 at LSB, each at its fixed offset.
- loge_valid  in  LOGE_CHANNEL_CNT  per-channel loge event this cycle.
- in_ready  out  1  all event inputs are consumed this cycle.
- record_bus  rr_stream_bus_t.P  -  valid/ready/data[FULL_WIDTH]/len[OFFSET_WIDTH] toward the storage backend.
- unit_cnt  out  64  logging units emitted (valid&ready on record_bus).
- stall_cnt  out  64  cycles with record_bus.valid=1 and ready=0.

Behaviour:
- Input beat: in_valid = |logb_valid | |loge_valid. An all-zero input is never a unit. Producers hold their inputs until in_ready=1.
- Unit format, LSB to MSB:
  - logb_valid bitmap in [LOGB-1:0];
  - loge_valid in [LOGB+LOGE-1:LOGB];
  - payloads of valid logb channels, compacted in ascending index order from bit LOGB+LOGE, with no gaps for invalid channels.
  - All bits at or above len are 0.
- len = LOGB + LOGE + sum of CHANNEL_WIDTHS[i] over valid i. Must equal the backend's bitmap-decoded length.
- Stage S1: registers bitmap, loge, raw payloads, and per-channel prefix offsets (sum of valid widths below i, OFFSET_WIDTH bits).
- Stage S2: registers compacted data and len; it drives record_bus.
- Advance rules:
  - s2_en = !s2_valid | record_bus.ready.
  - s1_en = !s1_valid | s2_en.
  - in_ready = s1_en.
  - s1_valid <= in_valid when s1_en.
  - s2_valid <= s1_valid when s2_en.
- Latency: accept at cycle N gives record_bus.valid=1 at N+2 when there is no backpressure. One unit per cycle sustained.
- Backpressure: data and len hold stable while valid & !ready. Both stages fill; in_ready deasserts only when S1 and S2 are both occupied and ready=0. No unit is dropped or duplicated.
- Simultaneous events: a unit leaving S2 and a new input entering S1 in the same cycle are both legal and are both counted.
- Counters: unit_cnt increments on record_bus.valid & ready. stall_cnt increments on valid & !ready. Both wrap modulo 2^64.
- Reset (asynchronous, any time including mid-stream):
  - s1_valid, s2_valid, record_bus.valid, unit_cnt and stall_cnt go to 0;
  - data and len go to 0;
  - in_ready goes to 1 once rstn=1.
  - In-flight units are discarded.
- Elaboration: $error if record_bus.FULL_WIDTH != FULL_WIDTH, or if any CHANNEL_WIDTHS[i]==0.

Decomposition:
- Shared package (cl_fpgarr_defs) holds:
  - RR_CHANNEL_WIDTH_BITS;
  - a GET_FULL_WIDTH-style constant function;
  - a unit-length function that sums widths from a bitmap, shared with the storage backend for consistency.
- Sub-module rr_packer_compact: combinational S2 compaction that shifts each valid payload to its prefix offset and ORs the results. Unit-testable on its own.

Test Plan:
- Defaults; logb_valid=3'b101, ch0=0xAB, ch2=0xDEADBEEF, loge=2'b01 -> after 2 cycles data[2:0]=101, [4:3]=01, [12:5]=0xAB, [44:13]=0xDEADBEEF, [60:45]=0, len=45.
- Only loge_valid=2'b10 -> data=5'b10000, len=5. All-zero inputs for 10 cycles -> no unit, unit_cnt unchanged.
- All logb and loge valid every cycle for 100 cycles, ready=1 -> 100 units back-to-back, each len=61, unit_cnt=100.
- ready=0 for 5 cycles while streaming -> in_ready drops after 2 accepts, data stable, stall_cnt=5, order preserved after release.
- rstn asserted with S1 and S2 both full -> valid=0 immediately (async), counters=0, next unit after release appears 2 cycles after its accept.
- Random bitmaps over 10k units with random ready -> each len matches a width-sum scoreboard, and unpacking reproduces the inputs exactly.
